// File: rtl/mul16_seq_ctrl_pkg.sv
// Shared types and constants for the
// sequential 16x16 multiplier controller.
package mul16_seq_ctrl_pkg;

  localparam int OPW   = 16;
  localparam int HALFW = 8;
  localparam int PRODW = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

endpackage

// File: rtl/arr_mul_8.sv
// 8x8 unsigned array multiplier built
// from gated shifted rows.
module arr_mul_8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  logic [15:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) begin
        sum = sum + ({8'b0, a_i} << i);
      end
    end
  end

  assign p_o = sum;

endmodule

// File: rtl/mul16_seq_ctrl.sv
// 16x16 unsigned multiplier sharing one
// 8x8 array multiplier over four phases.
module mul16_seq_ctrl
  import mul16_seq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRODW-1:0] product,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [OPW-1:0]     a_q, a_d;
  logic [OPW-1:0]     b_q, b_d;
  logic [PRODW-1:0]   acc_q, acc_d;

  logic [HALFW-1:0]   mul_a, mul_b;
  logic [2*HALFW-1:0] pp;
  logic [PRODW-1:0]   pp_ext, pp_sh;

  always_comb begin
    mul_a = a_q[HALFW-1:0];
    mul_b = b_q[HALFW-1:0];
    pp_sh = '0;
    unique case (phase_q)
      PH0: begin
        mul_a = a_q[HALFW-1:0];
        mul_b = b_q[HALFW-1:0];
        pp_sh = pp_ext;
      end
      PH1: begin
        mul_a = a_q[OPW-1:HALFW];
        mul_b = b_q[HALFW-1:0];
        pp_sh = pp_ext << HALFW;
      end
      PH2: begin
        mul_a = a_q[HALFW-1:0];
        mul_b = b_q[OPW-1:HALFW];
        pp_sh = pp_ext << HALFW;
      end
      PH3: begin
        mul_a = a_q[OPW-1:HALFW];
        mul_b = b_q[OPW-1:HALFW];
        pp_sh = pp_ext << OPW;
      end
      default: pp_sh = '0;
    endcase
  end

  arr_mul_8 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (pp)
  );

  assign pp_ext = {{(PRODW-2*HALFW){1'b0}}, pp};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          phase_d = PH0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d   = acc_q + pp_sh;
        phase_d = phase_q + 2'd1;
        if (phase_q == PH3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= PH0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = !busy;
  assign out_valid = (state_q == S_DONE);
  assign product   = acc_q;

endmodule

// File: doc/mul16_seq_ctrl.md
MUL16_SEQ_CTRL -- requirements
Module: mul16_seq_ctrl

Interface
REQ-001 SHALL have one clock domain; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  16  unsigned multiplicand.
REQ-007 b  input  16  unsigned multiplier.
REQ-008 out_valid  output  1  product available.
REQ-009 out_ready  input  1  consumer accepts product.
REQ-010 product  output  32  unsigned a*b.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL compute a 16x16 unsigned product by time-sharing one combinational 8x8 multiplier over 4 cycles.
REQ-013 States: IDLE, MUL, DONE. No other states are reachable.
REQ-014 in_ready = 1 only in IDLE. An accept is in_valid & in_ready at a rising edge.
REQ-015 On accept: latch a and b into operand registers, clear the 32-bit accumulator, set the 2-bit phase counter to 0, and go to MUL.
REQ-016 In MUL, each edge adds one partial product to the accumulator, then increments the phase counter.
  - Phase 0: aL*bL << 0.
  - Phase 1: aH*bL << 8.
  - Phase 2: aL*bH << 8.
  - Phase 3: aH*bH << 16.
REQ-017 Accumulator arithmetic is 32-bit unsigned with no overflow (the final sum is at most 0xFFFE0001), and the partial products are zero-extended before shifting.
REQ-018 The edge at phase 3 moves the block to DONE with out_valid=1 and product = the accumulated sum.
  - Latency: out_valid rises exactly 4 clocks after the accept edge.
REQ-019 In DONE, out_valid stays 1 and product holds stable until out_valid & out_ready at an edge; the block then returns to IDLE.
REQ-020 Minimum initiation interval is 6 cycles; a new accept never occurs in the same cycle as the result handoff.
REQ-021 in_valid while not in IDLE SHALL be ignored. It has no effect on the operand registers, the accumulator or the state.
REQ-022 Changes on a or b after the accept edge SHALL NOT affect the in-flight result.
REQ-023 out_ready while not in DONE SHALL be ignored.
REQ-024 busy SHALL be a pure decode of the state, and in_ready = !busy.

Reset
REQ-025 While rst_n=0 at an edge:
  - state goes to IDLE and the phase counter to 0;
  - the accumulator, product and operand registers go to 0;
  - out_valid=0, busy=0, in_ready=1 in the following cycle.
REQ-026 Reset during MUL or DONE SHALL discard the operation without emitting out_valid. The first accept after release behaves per REQ-015.
REQ-027 in_valid asserted in the same cycle as rst_n=0 SHALL NOT be accepted.

Structure
REQ-028 A shared package SHALL hold:
  - the state encoding (IDLE=2'd0, MUL=2'd1, DONE=2'd2);
  - the phase constants;
  - the widths OPW=16, HALFW=8, PRODW=32.
REQ-029 One sub-module, the existing 8x8 array multiplier arr_mul_8, SHALL be instantiated once, with its operand inputs selected by phase muxes.
REQ-030 All remaining logic lives in mul16_seq_ctrl and no other multiplier SHALL be inferred.

Verification
REQ-031 a=0x1234, b=0x5678, out_ready=1 -> out_valid high exactly 4 clocks after accept; product=0x06260060; back in IDLE the following cycle.
REQ-032 a=0xFFFF, b=0xFFFF -> product=0xFFFE0001; a=0x0000, b=0xABCD -> product=0x00000000.
REQ-033 Backpressure: result of a=0x00FF, b=0x0100; out_ready low 3 cycles after out_valid -> product=0x0000FF00 held stable with out_valid=1; handoff on the first out_ready=1 edge.
REQ-034 in_valid held high with a and b changing every cycle during MUL -> in_ready=0 throughout, and the result equals the product of the accepted pair only.
REQ-035 rst_n pulsed low at phase 2 of a=0x8000, b=0x0002 -> out_valid never rises; next accept of a=3, b=5 -> product=0x0000000F after 4 clocks.
REQ-036 A bench of at least 1000 random operand pairs with random out_ready -> every product matches a reference a*b, and no result is dropped or duplicated.
